fifo_sync_flags: RTL and testbench
==================================

Name: fifo_sync_flags

Overview:
- Parametrised single-clock FIFO; next generation of the team's push/pop FIFO block.
- Adds configurable depth and width, almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode.
- Sits between a producer and a consumer in the same clock domain.
- Keeps the existing signal vocabulary: push, pop, data_in, data_out, full, empty.

Parameters:
- WIDTH, 8: data word width in bits.
- DEPTH, 16: number of entries; power of 2, minimum 2.
- AF_THRESH, DEPTH-2: almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 1: almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1.
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- push  in  1  write request.
- data_in  in  WIDTH  write data, sampled when a push is accepted.
- pop  in  1  read request.
- data_out  out  WIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a push was rejected.
- underflow  out  1  sticky: a pop was rejected.
- clr_err  in  1  synchronous clear of overflow and underflow.

Behaviour:
- Reset, asynchronous on rst high:
  - wr_ptr, rd_ptr, count = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - overflow = 0, underflow = 0, data_out = 0.
  - Storage array is not reset.
  - Reset mid-operation discards all contents; the first push after release lands at address 0.
- Pointers: $clog2(DEPTH)+1 bits each.
  - The low bits address the storage; the MSB is a wrap bit.
  - Each pointer increments by 1 per accepted operation and wraps modulo 2*DEPTH.
  - count = wr_ptr - rd_ptr, computed modulo 2*DEPTH.
  - full when the low bits are equal and the MSBs differ; empty when the pointers are equal.
- Acceptance rules, evaluated on the registered state of the current cycle:
  - push_ok = push & !full.
  - pop_ok = pop & !empty.
  - A push to a full FIFO is dropped and sets overflow, even when a pop is accepted in the same cycle.
  - A pop from an empty FIFO is dropped and sets underflow, even when a push is accepted in the same cycle.
- Simultaneous push_ok and pop_ok: count is unchanged and both pointers advance.
- Flag latency:
  - All status outputs are functions of registered pointers, so they reflect an accepted operation in the following cycle.
  - Example: push into an empty FIFO at edge N gives empty = 0 after edge N.
- Standard read (FWFT = 0):
  - On pop_ok at edge N, data_out takes mem[rd_ptr] at edge N (one-cycle read latency).
  - data_out holds its value when no pop is accepted, including after the FIFO empties.
- FWFT read (FWFT = 1):
  - data_out = mem[rd_ptr] whenever !empty; pop_ok advances to the next word.
  - While empty, data_out holds its last registered value; it is 0 after reset.
  - The first word is visible the cycle after its push.
- Error flags:
  - overflow and underflow are set on a rejected operation and cleared by clr_err.
  - If clr_err and a new error occur in the same cycle, the flag ends up set.
- Elaboration checks: assertions reject a non-power-of-2 DEPTH and out-of-range thresholds.

Decomposition:
- fifo_pkg gains:
  - FIFO_WIDTH_DEF = 8 and FIFO_DEPTH_DEF = 16.
  - a parametrised data_ty width aligned to WIDTH.
  - an enum for read mode (STD, FWFT) mapped to the FWFT parameter.
- Sub-module fifo_mem:
  - WIDTH x DEPTH register array.
  - One synchronous write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata).
  - No reset.
- fifo_sync_flags holds the pointers, flags, error logic and read-mode muxing.

Test Plan (all scenarios use WIDTH=8, DEPTH=8, AF_THRESH=6, AE_THRESH=1):
- Reset / basic order: reset, push 0x11,0x22,0x33, then 3 pops (FWFT=0) -> data_out 0x11,0x22,0x33 one cycle after each pop; count 3→0; empty = 1 at end; no error flags.
- Fill and overflow: 8 pushes -> almost_full = 1 after the 6th, full = 1 after the 8th, count = 8. A 9th push -> data dropped, overflow = 1. It stays 1 until clr_err, then clears the next cycle.
- Underflow and clear race: pop while empty -> underflow = 1, data_out unchanged, count = 0. Then clr_err together with another empty pop -> underflow stays 1.
- Simultaneous push/pop:
  - With count = 4, push+pop for 20 cycles with incrementing data -> count stays 4; pointers wrap; output order matches input order.
  - With count = 8, push+pop -> pop accepted, push dropped, overflow = 1, count = 7.
- FWFT mode (FWFT=1): push 0xA5 into empty -> data_out = 0xA5 the next cycle with no pop. Push 0x5A, pop -> data_out = 0x5A the next cycle. Pop -> empty = 1, data_out holds 0x5A.
- Async reset mid-operation: with count = 5, assert rst between clock edges -> all flags and count take reset values immediately. After release, push 0x77 and pop -> 0x77 out; no stale data appears.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and defaults for the synchronous FIFO family.
// Read-mode selection is carried as an enum so the top can branch on a name rather than a bare bit.
package fifo_pkg;

  localparam int FIFO_WIDTH_DEF = 8;
  localparam int FIFO_DEPTH_DEF = 16;

  typedef logic [FIFO_WIDTH_DEF-1:0] data_ty;

  typedef enum logic {
    RD_STD  = 1'b0,
    RD_FWFT = 1'b1
  } read_mode_e;

  function automatic read_mode_e read_mode_of(input int fwft);
    return (fwft != 0) ? RD_FWFT : RD_STD;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage for the FIFO: register array, one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; validity is tracked by the pointers in the parent.
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds, sticky error flags
// and a selectable standard or first-word-fall-through read path.
module fifo_sync_flags
  import fifo_pkg::*;
#(
  parameter int WIDTH     = FIFO_WIDTH_DEF,
  parameter int DEPTH     = FIFO_DEPTH_DEF,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 1,
  parameter int FWFT      = 0,
  localparam int AW = $clog2(DEPTH),
  localparam int PW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [PW-1:0]    count,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  localparam read_mode_e    MODE = read_mode_of(FWFT);
  localparam logic [PW-1:0] AF_V = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_V = PW'(AE_THRESH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_sync_flags: DEPTH must be a power of 2 and at least 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("fifo_sync_flags: AF_THRESH out of range 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("fifo_sync_flags: AE_THRESH out of range 0..DEPTH-1");
  end

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] rdata;
  logic [WIDTH-1:0] dout_r;
  logic             push_ok;
  logic             pop_ok;

  // Status is derived purely from the registered pointers; the MSB acts as a wrap bit.
  assign count        = wr_ptr - rd_ptr;
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign almost_full  = (count >= AF_V);
  assign almost_empty = (count <= AE_V);

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (data_in),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // A new error in the same cycle as clr_err wins, so the flag ends up set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow  & ~clr_err) | (push & full);
      underflow <= (underflow & ~clr_err) | (pop & empty);
    end
  end

  // The popped word is captured in both modes: in FWFT it is the value held once the FIFO drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_r <= '0;
    end else if (pop_ok) begin
      dout_r <= rdata;
    end
  end

  always_comb begin
    data_out = dout_r;
    if (MODE == RD_FWFT && !empty) data_out = rdata;
  end

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Randomised and directed bench for fifo_sync_flags, running a standard and an FWFT instance
// side by side against a queue-based reference model.
module tb_fifo_sync_flags;

  localparam int W  = 8;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int AE = 1;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          push, pop, clr_err;
  logic [W-1:0]  data_in;

  logic [W-1:0]  dout_s, dout_f;
  logic [CW-1:0] count_s, count_f;
  logic          full_s, empty_s, af_s, ae_s, ovf_s, unf_s;
  logic          full_f, empty_f, af_f, ae_f, ovf_f, unf_f;

  always #5 clk = ~clk;

  fifo_sync_flags #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) dut_std (
    .clk(clk), .rst(rst), .push(push), .data_in(data_in), .pop(pop), .data_out(dout_s),
    .full(full_s), .empty(empty_s), .almost_full(af_s), .almost_empty(ae_s), .count(count_s),
    .overflow(ovf_s), .underflow(unf_s), .clr_err(clr_err)
  );

  fifo_sync_flags #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) dut_fwft (
    .clk(clk), .rst(rst), .push(push), .data_in(data_in), .pop(pop), .data_out(dout_f),
    .full(full_f), .empty(empty_f), .almost_full(af_f), .almost_empty(ae_f), .count(count_f),
    .overflow(ovf_f), .underflow(unf_f), .clr_err(clr_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the FIFO is just a queue; error flags and held outputs are plain bits.
  logic [W-1:0] q[$];
  bit           m_ovf, m_unf;
  logic [W-1:0] m_ds, m_df;

  task automatic model_reset();
    q.delete();
    m_ovf = 0;
    m_unf = 0;
    m_ds  = '0;
    m_df  = '0;
  endtask

  task automatic model_edge(input bit pu, input bit po, input bit cl, input logic [W-1:0] d);
    bit was_full, was_empty;
    logic [W-1:0] v;
    was_full  = (q.size() == D);
    was_empty = (q.size() == 0);
    m_ovf = (m_ovf && !cl) || (pu && was_full);
    m_unf = (m_unf && !cl) || (po && was_empty);
    if (po && !was_empty) begin
      v = q.pop_front();
      m_ds = v;
      m_df = v;
    end
    if (pu && !was_full) q.push_back(d);
  endtask

  task automatic check_all(input string ph);
    int n;
    logic [W-1:0] exp_f;
    n = q.size();
    exp_f = m_df;
    if (n > 0) exp_f = q[0];
    check({ph, ".count_s"}, 32'(count_s), 32'(n));
    check({ph, ".count_f"}, 32'(count_f), 32'(n));
    check({ph, ".empty"},   {30'd0, empty_s, empty_f}, {30'd0, n == 0, n == 0});
    check({ph, ".full"},    {30'd0, full_s, full_f},   {30'd0, n == D, n == D});
    check({ph, ".af"},      {30'd0, af_s, af_f},       {30'd0, n >= AF, n >= AF});
    check({ph, ".ae"},      {30'd0, ae_s, ae_f},       {30'd0, n <= AE, n <= AE});
    check({ph, ".ovf"},     {30'd0, ovf_s, ovf_f},     {30'd0, m_ovf, m_ovf});
    check({ph, ".unf"},     {30'd0, unf_s, unf_f},     {30'd0, m_unf, m_unf});
    check({ph, ".dout_s"},  32'(dout_s), 32'(m_ds));
    check({ph, ".dout_f"},  32'(dout_f), 32'(exp_f));
  endtask

  task automatic step(input string ph, input bit pu, input bit po, input bit cl,
                      input logic [W-1:0] d);
    push = pu; pop = po; clr_err = cl; data_in = d;
    @(posedge clk);
    model_edge(pu, po, cl, d);
    #1;
    check_all(ph);
  endtask

  initial begin
    push = 0; pop = 0; clr_err = 0; data_in = '0;
    rst = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 0;

    // basic order
    step("order", 1, 0, 0, 8'h11);
    step("order", 1, 0, 0, 8'h22);
    step("order", 1, 0, 0, 8'h33);
    repeat (3) step("order", 0, 1, 0, 8'h00);

    // fill, overflow, sticky hold, clear
    for (int i = 0; i < D; i++) step("fill", 1, 0, 0, 8'(8'h40 + i));
    step("ovf", 1, 0, 0, 8'hEE);
    step("ovf_hold", 0, 0, 0, 8'h00);
    step("ovf_hold", 0, 0, 0, 8'h00);
    step("ovf_clr", 0, 0, 1, 8'h00);
    repeat (D) step("drain", 0, 1, 0, 8'h00);

    // underflow and clear race
    step("unf", 0, 1, 0, 8'h00);
    step("unf_race", 0, 1, 1, 8'h00);
    step("unf_clr", 0, 0, 1, 8'h00);

    // simultaneous push/pop at count 4, wrapping the pointers
    for (int i = 0; i < 4; i++) step("pp_pre", 1, 0, 0, 8'(8'h80 + i));
    for (int i = 0; i < 20; i++) step("pp", 1, 1, 0, 8'(8'h90 + i));
    for (int i = 0; i < 4; i++) step("pp_fill", 1, 0, 0, 8'(8'hC0 + i));
    step("pp_full", 1, 1, 0, 8'hDD);
    step("pp_clr", 0, 0, 1, 8'h00);
    repeat (7) step("pp_drain", 0, 1, 0, 8'h00);

    // FWFT fall-through and hold
    step("fwft", 1, 0, 0, 8'hA5);
    step("fwft", 0, 0, 0, 8'h00);
    step("fwft", 1, 0, 0, 8'h5A);
    step("fwft", 0, 1, 0, 8'h00);
    step("fwft", 0, 1, 0, 8'h00);
    step("fwft", 0, 0, 0, 8'h00);

    // asynchronous reset between edges with count 5
    for (int i = 0; i < 5; i++) step("arst_pre", 1, 0, 0, 8'(8'h60 + i));
    push = 0; pop = 0; clr_err = 0;
    #2 rst = 1;
    #1;
    model_reset();
    check_all("arst");
    #1 rst = 0;
    step("arst_post", 1, 0, 0, 8'h77);
    step("arst_post", 0, 1, 0, 8'h00);
    step("arst_post", 0, 0, 0, 8'h00);

    // randomised traffic with drifting push/pop bias to visit both ends
    for (int i = 0; i < 600; i++) begin
      int bias;
      bias = ((i / 60) % 2 == 0) ? 75 : 25;
      step("rand", ($urandom_range(99) < bias), ($urandom_range(99) >= bias),
           ($urandom_range(15) == 0), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
